pipeline_sequencer: RTL and testbench
=====================================

Name: pipeline_sequencer

Overview:
- Central stall/flush/halt sequencer for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB).
- Handles four cases:
  - load-use hazards, detected in ID against EX;
  - taken branch/jump redirects, resolved in EX;
  - variable-latency data-memory handshakes in MEM, with a watchdog;
  - orderly HALT: drains in-flight instructions, then freezes the core.
- Drives the write enables and flushes of the PC and the pipeline registers. Sits beside the main decoder.

Parameters:
- DRAIN_CYCLES, 3, non-frozen cycles after HALT is accepted before halted asserts (EX, MEM, WB retire); legal range 1..7.
- MEM_TIMEOUT, 16, maximum consecutive wait cycles on dmem before mem_err; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_opcode  in  7  opcode of the instruction in ID.
- id_rs1  in  5  rs1 field in ID.
- id_rs2  in  5  rs2 field in ID.
- ex_memread  in  1  EX instruction is a load.
- ex_rd  in  5  EX destination register.
- ex_pc_sel  in  1  EX resolved a taken branch, JAL or JALR.
- mem_access  in  1  MEM instruction is a load or a store.
- dmem_ready  in  1  data memory completes the current access this cycle.
- dmem_req  out  1  access request to data memory.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register enable.
- ifid_flush  out  1  IF/ID is loaded with a bubble.
- idex_write  out  1  ID/EX register enable.
- idex_flush  out  1  ID/EX is loaded with a bubble (all controls 0).
- back_write  out  1  EX/MEM and MEM/WB enable.
- halted  out  1  core halted.
- mem_err  out  1  sticky memory timeout flag.

Behaviour:
- FSM states: RUN, DRAIN, HALTED. State, drain counter (3 bit), wait counter (8 bit) and mem_err are registers. All outputs are decoded combinationally from state and inputs.
- Reset, asynchronous: state=RUN, counters=0, mem_err=0.
  - While reset is high, every output is 0: pc_write, ifid_write, idex_write, back_write, flushes, dmem_req, halted.
- Operand usage by opcode:
  - rs1 used by 0110011, 0000011, 0100011, 1100011, 0010011, 1100111.
  - rs2 used by 0110011, 0100011, 1100011.
  - HALT opcode is 1111111.
- freeze = mem_access & !dmem_ready, in RUN or DRAIN.
- dmem_req = mem_access in RUN or DRAIN.
- Priority in RUN, highest first:
  1. freeze: every write enable 0, both flushes 0, whole pipeline holds. wait_cnt increments. If wait_cnt reaches MEM_TIMEOUT-1 while still frozen, the next edge sets mem_err=1 and goes to HALTED.
  2. ex_pc_sel: pc_write=1, ifid_flush=1, idex_flush=1, other enables 1. A HALT in ID is killed, so no DRAIN entry.
  3. load-use: ex_memread & ex_rd!=0 & ((ex_rd==id_rs1 & uses_rs1) | (ex_rd==id_rs2 & uses_rs2)). Gives pc_write=0, ifid_write=0, idex_flush=1, back_write=1. Exactly one bubble per hazard.
  4. id_opcode==HALT: same enables as load-use (halt is held in ID, bubble inserted). Next state DRAIN, drain_cnt=DRAIN_CYCLES-1.
  5. Otherwise: all enables 1, flushes 0.
- wait_cnt clears on any non-frozen cycle.
- DRAIN:
  - pc_write=0, ifid_write=0, idex_flush=1, back_write=1 unless frozen.
  - drain_cnt decrements on non-frozen cycles only.
  - drain_cnt==0 and not frozen → HALTED.
  - ex_pc_sel cannot occur in DRAIN (only bubbles in EX) and is ignored.
  - The watchdog is active as in RUN.
- HALTED: halted=1, all enables, flushes and dmem_req 0. Absorbing until reset.
- mem_err=1 implies halted=1.
- Reset mid-freeze or mid-drain: returns to RUN immediately. No partial state survives.

Decomposition:
- riscv_pkg gets:
  - opcode constants OP_RTYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_ITYPE, OP_JAL, OP_JALR, OP_HALT;
  - seq_state_t enum {RUN, DRAIN, HALTED}.
- One combinational sub-module, hazard_detect: opcode-to-usage decode plus the load-use compare, output load_use. The sequencer owns the FSM and counters.

Test Plan:
- lw x5 in EX (ex_memread=1, ex_rd=5); add x6,x5,x7 in ID → one cycle with pc_write=0, ifid_write=0, idex_flush=1; next cycle all enables 1.
- Same hazard with ex_rd=0, or with ID opcode JAL → no stall.
- ex_pc_sel=1 together with load-use and HALT in ID → ifid_flush=idex_flush=1, pc_write=1, state stays RUN.
- mem_access=1, dmem_ready low for 4 cycles → all enables 0 for 4 cycles, dmem_req=1 throughout; on cycle 5 ready=1 → normal, mem_err=0.
- dmem_ready held low with MEM_TIMEOUT=16 → mem_err=1 and halted=1 after the 16th wait edge; both sticky.
- HALT in ID, DRAIN_CYCLES=3, one 2-cycle freeze mid-drain → halted rises 5 cycles after acceptance. Reset pulse then clears halted and returns to RUN.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared opcode constants and sequencer state encoding for the 5-stage core.
package riscv_pkg;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_HALT   = 7'b1111111;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } seq_state_t;

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Pipeline-status inputs and stall/flush controls between the core datapath (master) and the sequencer (slave).
interface pipeline_sequencer_if;

   logic [6:0] id_opcode;
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic       ex_memread;
   logic [4:0] ex_rd;
   logic       ex_pc_sel;
   logic       mem_access;
   logic       dmem_ready;

   logic       dmem_req;
   logic       pc_write;
   logic       ifid_write;
   logic       ifid_flush;
   logic       idex_write;
   logic       idex_flush;
   logic       back_write;
   logic       halted;
   logic       mem_err;

   modport master (
      output id_opcode, id_rs1, id_rs2, ex_memread, ex_rd, ex_pc_sel, mem_access, dmem_ready,
      input  dmem_req, pc_write, ifid_write, ifid_flush, idex_write, idex_flush, back_write,
             halted, mem_err
   );

   modport slave (
      input  id_opcode, id_rs1, id_rs2, ex_memread, ex_rd, ex_pc_sel, mem_access, dmem_ready,
      output dmem_req, pc_write, ifid_write, ifid_flush, idex_write, idex_flush, back_write,
             halted, mem_err
   );

endinterface

// File: rtl/pipeline_sequencer_hazard_detect.sv
// Load-use hazard check: ID operand usage decoded from opcode, compared against a load in EX.
// Purely combinational.
module hazard_detect
   import riscv_pkg::*;
(
   input  logic [6:0] id_opcode_i,
   input  logic [4:0] id_rs1_i,
   input  logic [4:0] id_rs2_i,
   input  logic       ex_memread_i,
   input  logic [4:0] ex_rd_i,
   output logic       load_use_o
);

   logic uses_rs1;
   logic uses_rs2;

   always_comb begin
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      case (id_opcode_i)
         OP_RTYPE, OP_STORE, OP_BRANCH: begin
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
         end
         OP_LOAD, OP_ITYPE, OP_JALR: uses_rs1 = 1'b1;
         default: ;
      endcase
   end

   // x0 is never a real producer, so a load targeting it cannot create a hazard
   assign load_use_o = ex_memread_i && (ex_rd_i != 5'd0) &&
                       (((ex_rd_i == id_rs1_i) && uses_rs1) ||
                        ((ex_rd_i == id_rs2_i) && uses_rs2));

endmodule

// File: rtl/pipeline_sequencer.sv
// Stall/flush/halt sequencer: RUN/DRAIN/HALTED FSM, dmem wait watchdog, drain counter.
// Outputs decoded combinationally from state and inputs; all forced low while reset is high.
module pipeline_sequencer
   import riscv_pkg::*;
#(
   parameter int DRAIN_CYCLES = 3,
   parameter int MEM_TIMEOUT  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   pipeline_sequencer_if.slave  seq
);

   localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES - 1);
   localparam logic [7:0] WAIT_LAST  = 8'(MEM_TIMEOUT - 1);

   seq_state_t state_q, state_d;
   logic [2:0] drain_cnt_q, drain_cnt_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       mem_err_q, mem_err_d;

   logic load_use;
   logic is_halt;
   logic frozen;

   logic dmem_req, pc_write, ifid_write, ifid_flush;
   logic idex_write, idex_flush, back_write, halted;

   hazard_detect u_hazard_detect (
      .id_opcode_i  (seq.id_opcode),
      .id_rs1_i     (seq.id_rs1),
      .id_rs2_i     (seq.id_rs2),
      .ex_memread_i (seq.ex_memread),
      .ex_rd_i      (seq.ex_rd),
      .load_use_o   (load_use)
   );

   assign is_halt = (seq.id_opcode == OP_HALT);
   assign frozen  = (state_q != HALTED) && seq.mem_access && !seq.dmem_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= RUN;
         drain_cnt_q <= 3'd0;
         wait_cnt_q  <= 8'd0;
         mem_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         mem_err_q   <= mem_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      wait_cnt_d  = 8'd0;
      mem_err_d   = mem_err_q;
      dmem_req    = 1'b0;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_write  = 1'b0;
      idex_flush  = 1'b0;
      back_write  = 1'b0;
      halted      = 1'b0;

      case (state_q)
         RUN, DRAIN: begin
            dmem_req = seq.mem_access;
            if (frozen) begin
               wait_cnt_d = wait_cnt_q + 8'd1;
               if (wait_cnt_q == WAIT_LAST) begin
                  mem_err_d = 1'b1;
                  state_d   = HALTED;
               end
            end else if (state_q == DRAIN) begin
               idex_write = 1'b1;
               idex_flush = 1'b1;
               back_write = 1'b1;
               if (drain_cnt_q == 3'd0) begin
                  state_d = HALTED;
               end else begin
                  drain_cnt_d = drain_cnt_q - 3'd1;
               end
            end else if (seq.ex_pc_sel) begin
               // Redirect kills whatever sits in IF/ID, including a HALT
               pc_write   = 1'b1;
               ifid_write = 1'b1;
               ifid_flush = 1'b1;
               idex_write = 1'b1;
               idex_flush = 1'b1;
               back_write = 1'b1;
            end else if (load_use || is_halt) begin
               idex_write = 1'b1;
               idex_flush = 1'b1;
               back_write = 1'b1;
               if (is_halt) begin
                  state_d     = DRAIN;
                  drain_cnt_d = DRAIN_INIT;
               end
            end else begin
               pc_write   = 1'b1;
               ifid_write = 1'b1;
               idex_write = 1'b1;
               back_write = 1'b1;
            end
         end
         HALTED: halted = 1'b1;
         default: state_d = RUN;
      endcase

      if (reset) begin
         dmem_req   = 1'b0;
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         ifid_flush = 1'b0;
         idex_write = 1'b0;
         idex_flush = 1'b0;
         back_write = 1'b0;
         halted     = 1'b0;
      end
   end

   assign seq.dmem_req   = dmem_req;
   assign seq.pc_write   = pc_write;
   assign seq.ifid_write = ifid_write;
   assign seq.ifid_flush = ifid_flush;
   assign seq.idex_write = idex_write;
   assign seq.idex_flush = idex_flush;
   assign seq.back_write = back_write;
   assign seq.halted     = halted;
   assign seq.mem_err    = mem_err_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed scenarios plus randomized traffic checked against a cycle-level behavioural model.
module tb_pipeline_sequencer;
   import riscv_pkg::*;

   localparam int DRAIN_N   = 3;
   localparam int TIMEOUT_N = 16;

   // Output vector: {dmem_req, pc_write, ifid_write, ifid_flush, idex_write, idex_flush, back_write, halted, mem_err}
   localparam logic [8:0] O_NORMAL   = 9'b011010100;
   localparam logic [8:0] O_STALL    = 9'b000011100;
   localparam logic [8:0] O_REDIRECT = 9'b011111100;
   localparam logic [8:0] O_FREEZE   = 9'b100000000;
   localparam logic [8:0] O_HALTED   = 9'b000000010;
   localparam logic [8:0] O_ERR      = 9'b000000011;
   localparam logic [8:0] O_ZERO     = 9'b000000000;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;

   pipeline_sequencer_if sif();

   pipeline_sequencer #(.DRAIN_CYCLES(DRAIN_N), .MEM_TIMEOUT(TIMEOUT_N)) dut (
      .clk   (clk),
      .reset (reset),
      .seq   (sif.slave)
   );

   always #5 clk = ~clk;

   logic [8:0] obs;
   assign obs = {sif.dmem_req, sif.pc_write, sif.ifid_write, sif.ifid_flush, sif.idex_write,
                 sif.idex_flush, sif.back_write, sif.halted, sif.mem_err};

   // Behavioural model state
   bit m_halted, m_err, m_draining;
   int m_drain_left, m_stall_run;

   task automatic drive(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic memread, input logic [4:0] rd, input logic pcsel,
                        input logic mem, input logic rdy);
      sif.id_opcode  = op;
      sif.id_rs1     = rs1;
      sif.id_rs2     = rs2;
      sif.ex_memread = memread;
      sif.ex_rd      = rd;
      sif.ex_pc_sel  = pcsel;
      sif.mem_access = mem;
      sif.dmem_ready = rdy;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse();
      reset = 1'b1;
      drive(OP_ITYPE, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      next_cycle();
      next_cycle();
      reset = 1'b0;
   endtask

   function automatic bit reads_reg(input logic [6:0] op, input logic [4:0] r, input logic [4:0] rs1,
                                    input logic [4:0] rs2);
      bit r1, r2;
      r1 = op inside {OP_RTYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_ITYPE, OP_JALR};
      r2 = op inside {OP_RTYPE, OP_STORE, OP_BRANCH};
      return (r1 && rs1 == r) || (r2 && rs2 == r);
   endfunction

   function automatic logic [8:0] model_expect();
      logic [8:0] e;
      bit waiting;
      waiting = sif.mem_access && !sif.dmem_ready;
      if (reset) return O_ZERO;
      if (m_halted) return m_err ? O_ERR : O_HALTED;
      if (waiting) return O_FREEZE;
      if (m_draining) e = O_STALL;
      else if (sif.ex_pc_sel) e = O_REDIRECT;
      else if ((sif.ex_memread && sif.ex_rd != 0 &&
                reads_reg(sif.id_opcode, sif.ex_rd, sif.id_rs1, sif.id_rs2)) ||
               sif.id_opcode == OP_HALT) e = O_STALL;
      else e = O_NORMAL;
      e[8] = sif.mem_access;
      return e;
   endfunction

   task automatic model_clock_edge();
      bit waiting;
      waiting = sif.mem_access && !sif.dmem_ready;
      if (reset) begin
         m_halted = 0; m_err = 0; m_draining = 0; m_drain_left = 0; m_stall_run = 0;
      end else if (!m_halted) begin
         if (waiting) begin
            m_stall_run++;
            if (m_stall_run == TIMEOUT_N) begin
               m_err = 1; m_halted = 1;
            end
         end else begin
            m_stall_run = 0;
            if (m_draining) begin
               m_drain_left--;
               if (m_drain_left == 0) begin
                  m_draining = 0; m_halted = 1;
               end
            end else if (!sif.ex_pc_sel && sif.id_opcode == OP_HALT) begin
               m_draining = 1; m_drain_left = DRAIN_N;
            end
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(OP_HALT, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== O_ZERO) begin
            failures++;
            $display("FAIL reset_outputs cyc%0d: got %b expected %b", i, obs, O_ZERO);
         end
      end
      next_cycle();
      reset = 1'b0;
      drive(OP_RTYPE, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (obs !== O_NORMAL) begin
         failures++;
         $display("FAIL reset_release: got %b expected %b", obs, O_NORMAL);
      end
      next_cycle();
   endtask

   task automatic test_load_use();
      reset_pulse();
      drive(OP_RTYPE, 5'd5, 5'd7, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (obs !== O_STALL) begin
         failures++;
         $display("FAIL load_use_rs1: got %b expected %b", obs, O_STALL);
      end
      next_cycle();
      drive(OP_RTYPE, 5'd5, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (obs !== O_NORMAL) begin
         failures++;
         $display("FAIL load_use_release: got %b expected %b", obs, O_NORMAL);
      end
      next_cycle();
      drive(OP_STORE, 5'd1, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (obs !== O_STALL) begin
         failures++;
         $display("FAIL load_use_rs2: got %b expected %b", obs, O_STALL);
      end
      next_cycle();
   endtask

   task automatic test_no_stall();
      reset_pulse();
      drive(OP_RTYPE, 5'd0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (obs !== O_NORMAL) begin
         failures++;
         $display("FAIL no_stall_x0: got %b expected %b", obs, O_NORMAL);
      end
      next_cycle();
      drive(OP_JAL, 5'd5, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (obs !== O_NORMAL) begin
         failures++;
         $display("FAIL no_stall_jal: got %b expected %b", obs, O_NORMAL);
      end
      next_cycle();
      drive(OP_ITYPE, 5'd3, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (obs !== O_NORMAL) begin
         failures++;
         $display("FAIL no_stall_itype_rs2: got %b expected %b", obs, O_NORMAL);
      end
      next_cycle();
   endtask

   task automatic test_redirect_priority();
      reset_pulse();
      drive(OP_RTYPE, 5'd5, 5'd7, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (obs !== O_REDIRECT) begin
         failures++;
         $display("FAIL redirect_over_load_use: got %b expected %b", obs, O_REDIRECT);
      end
      next_cycle();
      drive(OP_HALT, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (obs !== O_REDIRECT) begin
         failures++;
         $display("FAIL redirect_over_halt: got %b expected %b", obs, O_REDIRECT);
      end
      next_cycle();
      drive(OP_RTYPE, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (obs !== O_NORMAL) begin
         failures++;
         $display("FAIL redirect_stays_run: got %b expected %b", obs, O_NORMAL);
      end
      next_cycle();
   endtask

   task automatic test_mem_freeze();
      reset_pulse();
      for (int i = 0; i < 4; i++) begin
         drive(OP_RTYPE, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
         @(negedge clk);
         checks++;
         if (obs !== O_FREEZE) begin
            failures++;
            $display("FAIL freeze_wait%0d: got %b expected %b", i, obs, O_FREEZE);
         end
         next_cycle();
      end
      drive(OP_RTYPE, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      checks++;
      if (obs !== (O_NORMAL | 9'b100000000)) begin
         failures++;
         $display("FAIL freeze_release: got %b expected %b", obs, O_NORMAL | 9'b100000000);
      end
      next_cycle();
   endtask

   task automatic test_mem_timeout();
      reset_pulse();
      for (int i = 0; i < TIMEOUT_N; i++) begin
         drive(OP_LOAD, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
         @(negedge clk);
         checks++;
         if (obs !== O_FREEZE) begin
            failures++;
            $display("FAIL timeout_wait%0d: got %b expected %b", i, obs, O_FREEZE);
         end
         next_cycle();
      end
      for (int i = 0; i < 3; i++) begin
         drive(OP_RTYPE, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
         @(negedge clk);
         checks++;
         if (obs !== O_ERR) begin
            failures++;
            $display("FAIL timeout_sticky%0d: got %b expected %b", i, obs, O_ERR);
         end
         next_cycle();
      end
   endtask

   task automatic test_drain_with_freeze();
      logic [8:0] exp_seq [6];
      logic       mem_seq [6];
      logic       rdy_seq [6];
      exp_seq = '{O_STALL, O_FREEZE, O_FREEZE, O_STALL | 9'b100000000, O_STALL, O_HALTED};
      mem_seq = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      rdy_seq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      reset_pulse();
      drive(OP_HALT, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (obs !== O_STALL) begin
         failures++;
         $display("FAIL halt_accept: got %b expected %b", obs, O_STALL);
      end
      next_cycle();
      for (int i = 0; i < 6; i++) begin
         drive(OP_HALT, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, mem_seq[i], rdy_seq[i]);
         @(negedge clk);
         checks++;
         if (obs !== exp_seq[i]) begin
            failures++;
            $display("FAIL drain_step%0d: got %b expected %b", i, obs, exp_seq[i]);
         end
         next_cycle();
      end
      reset_pulse();
      drive(OP_RTYPE, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (obs !== O_NORMAL) begin
         failures++;
         $display("FAIL halt_cleared_by_reset: got %b expected %b", obs, O_NORMAL);
      end
      next_cycle();
   endtask

   task automatic test_random();
      logic [6:0] ops [9];
      logic [8:0] exp;
      ops = '{OP_RTYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_ITYPE, OP_JAL, OP_JALR, OP_HALT, 7'b0110111};
      reset_pulse();
      m_halted = 0; m_err = 0; m_draining = 0; m_drain_left = 0; m_stall_run = 0;
      for (int c = 0; c < 1500; c++) begin
         reset = ($urandom_range(0, 59) == 0);
         drive(($urandom_range(0, 11) == 0) ? OP_HALT : ops[$urandom_range(0, 8)],
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 3) == 0) ? 1'b0 : 1'($urandom_range(0, 1)));
         // Occasionally hold memory busy long enough to hit the watchdog
         if (c % 300 > 280) begin
            sif.mem_access = 1'b1;
            sif.dmem_ready = 1'b0;
            reset = 1'b0;
         end
         @(negedge clk);
         exp = model_expect();
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL random_cyc%0d: got %b expected %b", c, obs, exp);
         end
         @(posedge clk);
         model_clock_edge();
         #1;
      end
      reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      drive(OP_ITYPE, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      test_reset();
      test_load_use();
      test_no_stall();
      test_redirect_priority();
      test_mem_freeze();
      test_mem_timeout();
      test_drain_with_freeze();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
